// File: rtl/mips_data_mem_ctrl_pkg.sv
// Shared types and helpers for the MIPS data-memory controller.
// Package name is mips_mem_pkg; it is imported by the interface, the RAM and the top.
package mips_mem_pkg;

    localparam int BYTE_W     = 8;
    localparam int WCNT_W     = 4;
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Expands byte enables into a bit mask; callers cast the result down to their own width.
    function automatic logic [MAX_DATA_W-1:0] lane_mask(input logic [MAX_BE_W-1:0] be);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BE_W; i++) begin
            m[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mips_data_mem_ctrl_if.sv
// Load/store port between the CPU (master) and the data-memory controller (slave).
interface mips_data_mem_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic                     req;
    logic                     we;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W/BYTE_W-1:0] be;
    logic [DATA_W-1:0]        wdata;
    logic                     busy;
    logic                     ack;
    logic [DATA_W-1:0]        rdata;
    logic                     err;

    modport master (
        output req, we, addr, be, wdata,
        input  busy, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output busy, ack, rdata, err
    );

endinterface

// File: rtl/mips_data_mem_ctrl_byte_ram.sv
// Single-port word array with per-byte write enables and a registered read port.
// Module name is mips_byte_ram; contents start undefined and are filled by writes.
module mips_byte_ram
  import mips_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter     INIT_FILE = ""
) (
  input  logic                     clock,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mask;

  assign mask = DATA_W'(lane_mask(MAX_BE_W'(be)));

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mips_data_mem_ctrl.sv
// Byte-enabled data memory with req/ack handshake and WAIT_CYCLES wait states.
// Optional DMEM_BOUNDS_CHECK_EN: out-of-range or misaligned full-word accesses ack with err.
module mips_data_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0,
    parameter     INIT_FILE   = ""
) (
    input logic             clock,
    input logic             reset,
    mips_data_mem_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / BYTE_W;

    state_t              state;
    state_t              state_nxt;
    logic [WCNT_W-1:0]   wcnt;
    logic                accept;

    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [BE_W-1:0]     lat_be;
    logic [DATA_W-1:0]   lat_wdata;

    logic                access;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [BE_W-1:0]     acc_be;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_err;

    logic                ack_q;
    logic                err_q;
    logic [DATA_W-1:0]   ram_rdata;

    assign accept = (state == IDLE) && bus.req && !reset;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (wcnt == WCNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With no wait states the array is touched on the accept edge, so the live bus is used.
    always_comb begin
        access    = 1'b0;
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_be    = lat_be;
        acc_wdata = lat_wdata;
        case (state)
            IDLE: begin
                acc_we    = bus.we;
                acc_addr  = bus.addr;
                acc_be    = bus.be;
                acc_wdata = bus.wdata;
                access    = bus.req && (WAIT_CYCLES == 0);
            end
            WAIT:    access = (wcnt == WCNT_W'(1));
            default: access = 1'b0;
        endcase
        if (reset) access = 1'b0;
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign acc_err = ((acc_addr >> 2) >= ADDR_W'(DEPTH)) ||
                     ((acc_addr[1:0] != 2'b00) && (acc_be == {BE_W{1'b1}}));
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[ADDR_W-1:IDX_W+2], acc_addr[1:0]};
    assign acc_err          = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (accept) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_be    <= bus.be;
            lat_wdata <= bus.wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)               wcnt <= '0;
        else if (accept)         wcnt <= WCNT_W'(WAIT_CYCLES);
        else if (state == WAIT)  wcnt <= wcnt - WCNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= access;
            err_q <= access && acc_err;
        end
    end

    mips_byte_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clock (clock),
        .en    (access),
        .we    (acc_we && !acc_err),
        .addr  (acc_addr[IDX_W+1:2]),
        .be    (acc_be),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // busy also covers the accept cycle itself, so the master sees it while req is being taken.
    assign bus.busy  = (state != IDLE) || accept;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = (ack_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mips_data_mem_ctrl.sv
// Bench for mips_data_mem_ctrl: three instances (0, 1 and 3 wait states) against an array model.
module tb_mips_data_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  busy;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [3][256];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_data_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        assign bus.req   = req[g];
        assign bus.we    = we;
        assign bus.addr  = addr;
        assign bus.be    = be;
        assign bus.wdata = wdata;
        assign busy[g]   = bus.busy;
        assign ack[g]    = bus.ack;
        assign err[g]    = bus.err;
        assign rdata[g]  = bus.rdata;
        mips_data_mem_ctrl #(
            .DATA_W      (32),
            .DEPTH       (256),
            .ADDR_W      (32),
            .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
            .INIT_FILE   ("")
        ) u_dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );
    end

    function automatic int wc(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic bit exp_err(input logic [31:0] a, input logic [3:0] b);
`ifdef DMEM_BOUNDS_CHECK_EN
        return ((a >> 2) >= 32'd256) || ((a % 4) != 0 && b == 4'hF);
`else
        return (a != a);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance d, checked against the model as it goes.
    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] wd, output logic [31:0] rd, output int nb);
        int          n;
        int          idx;
        bit          e;
        logic [31:0] exp_rd;
        idx    = int'((a / 4) % 256);
        e      = exp_err(a, b);
        exp_rd = model[d][idx];
        if (w && !e)
            for (int i = 0; i < 4; i++)
                if (b[i]) model[d][idx][i*8 +: 8] = wd[i*8 +: 8];
        nb = 0;
        @(negedge clock);
        we = w; addr = a; be = b; wdata = wd; req[d] = 1'b1;
        #1;
        chk("busy_accept", {31'd0, busy[d]}, 32'd1);
        if (busy[d] === 1'b1) nb++;
        @(posedge clock); #1;
        we = 1'($urandom); addr = $urandom; be = 4'($urandom); wdata = $urandom;
        n = 1;
        while (ack[d] !== 1'b1 && n < 40) begin
            chk("busy_wait", {31'd0, busy[d]}, 32'd1);
            chk("rdata_wait", rdata[d], 32'd0);
            if (busy[d] === 1'b1) nb++;
            @(posedge clock); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(wc(d) + 1));
        chk("busy_ack", {31'd0, busy[d]}, 32'd1);
        if (busy[d] === 1'b1) nb++;
        chk("err", {31'd0, err[d]}, {31'd0, e});
        if (!w || e) chk("rdata", rdata[d], e ? 32'd0 : exp_rd);
        rd = rdata[d];
        req[d] = 1'b0;
        @(posedge clock); #1;
        chk("ack_drop", {31'd0, ack[d]}, 32'd0);
        chk("busy_drop", {31'd0, busy[d]}, 32'd0);
        chk("rdata_zero", rdata[d], 32'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          nb;
        int          k;
        int          first_ack;
        int          second_ack;
        logic [31:0] rd2;

        reset = 1'b1; req = '0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", {31'd0, busy[d]}, 32'd0);
            chk("rst_ack", {31'd0, ack[d]}, 32'd0);
            chk("rst_err", {31'd0, err[d]}, 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 256; i++)
                access(d, 1'b1, 32'(i * 4), 4'hF, $urandom, rd, nb);

        // Write then read word 2 with no wait states.
        access(0, 1'b1, 32'h8, 4'hF, 32'h9, rd, nb);
        access(0, 1'b0, 32'h8, 4'hF, 32'h0, rd, nb);
        chk("t1_rdata", rd, 32'h9);

        // Three wait states: busy spans accept through ack.
        access(2, 1'b1, 32'h4, 4'hF, 32'h8, rd, nb);
        access(2, 1'b0, 32'h4, 4'hF, 32'h0, rd, nb);
        chk("t2_rdata", rd, 32'h8);
        chk("t2_busy_cycles", 32'(nb), 32'd5);

        // Byte lanes.
        access(1, 1'b1, 32'h10, 4'hF, 32'h0000_000A, rd, nb);
        access(1, 1'b1, 32'h10, 4'b0010, 32'hDEAD_BEEF, rd, nb);
        access(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, nb);
        chk("t3_lane1", rd, 32'h0000_BE0A);
        access(1, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, rd, nb);
        access(1, 1'b0, 32'h12, 4'h1, 32'h0, rd, nb);
        chk("t3_be0", rd, 32'h0000_BE0A);

        // Reset during the final wait cycle of a write drops it.
        access(2, 1'b1, 32'h14, 4'hF, 32'h6, rd, nb);
        @(negedge clock);
        we = 1'b1; addr = 32'h14; be = 4'hF; wdata = 32'h55; req[2] = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("t4_no_ack_yet", {31'd0, ack[2]}, 32'd0);
        reset = 1'b1; req[2] = 1'b0;
        @(posedge clock); #1;
        chk("t4_busy", {31'd0, busy[2]}, 32'd0);
        chk("t4_ack", {31'd0, ack[2]}, 32'd0);
        chk("t4_err", {31'd0, err[2]}, 32'd0);
        chk("t4_rdata", rdata[2], 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("t4_quiet", {31'd0, ack[2]}, 32'd0);
        end
        access(2, 1'b0, 32'h14, 4'hF, 32'h0, rd, nb);
        chk("t4_word5", rd, 32'h6);

        // req held through ack: second request starts in the IDLE cycle after ack.
        first_ack = -1; second_ack = -1; rd2 = '0;
        @(negedge clock);
        we = 1'b1; addr = 32'h1C; be = 4'hF; wdata = 32'h1234_5677; req[1] = 1'b1;
        k = 0;
        while (second_ack < 0 && k < 20) begin
            @(posedge clock); #1;
            k++;
            if (ack[1] === 1'b1) begin
                if (first_ack < 0) begin
                    first_ack = k;
                    we = 1'b0; wdata = 32'h0;
                end else begin
                    second_ack = k;
                    rd2 = rdata[1];
                    req[1] = 1'b0;
                end
            end
        end
        model[1][7] = 32'h1234_5677;
        chk("t5_first_ack", 32'(first_ack), 32'd2);
        chk("t5_ack_spacing", 32'(second_ack - first_ack), 32'd3);
        chk("t5_rdata", rd2, 32'h1234_5677);
        @(posedge clock); #1;

        // Address beyond the array.
        access(0, 1'b1, 32'h0, 4'hF, 32'hCAFE_0000, rd, nb);
        access(0, 1'b1, 32'h400, 4'hF, 32'h1234_5678, rd, nb);
        access(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, nb);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("t6_word0", rd, 32'hCAFE_0000);
`else
        chk("t6_word0", rd, 32'h1234_5678);
`endif

        for (int i = 0; i < 200; i++)
            access(int'($urandom_range(0, 2)), 1'($urandom), 32'($urandom_range(0, 32'h7FF)),
                   4'($urandom), $urandom, rd, nb);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
